// File: rtl/segment_scan_mux_if.sv
// Display-side bundle for segment_scan_mux: scan enable, four digit codes,
// brightness in; shared segment bus, digit strobes and frame pulse out.
interface segment_scan_mux_if;
    logic       en_i;
    logic [6:0] seg_hxxx_i;
    logic [6:0] seg_xhxx_i;
    logic [6:0] seg_xxmx_i;
    logic [6:0] seg_xxxm_i;
    logic [2:0] bright_i;
    logic [6:0] seg_o;
    logic [3:0] dig_o;
    logic       frame_o;

    modport master (
        output en_i, seg_hxxx_i, seg_xhxx_i, seg_xxmx_i, seg_xxxm_i, bright_i,
        input  seg_o, dig_o, frame_o
    );

    modport slave (
        input  en_i, seg_hxxx_i, seg_xhxx_i, seg_xxmx_i, seg_xxxm_i, bright_i,
        output seg_o, dig_o, frame_o
    );
endinterface

// File: rtl/segment_scan_mux.sv
// 4-digit multiplexed 7-segment scanner with per-frame capture, blank slot lead-in
// and 8-level PWM. Define SEG_ACTIVE_LOW_EN for inverted (common-anode) seg_o/dig_o.
module segment_scan_mux #(
    parameter int SCAN_DIV = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    segment_scan_mux_if.slave     bus
);
    localparam int              CW     = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]   C_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   C_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   C_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW:0]     W_ONE  = {{CW{1'b0}}, 1'b1};
    localparam logic [CW:0]     STEP   = (CW+1)'(SCAN_DIV / 8);

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic [6:0] SEG_POL = 7'h7F;
    localparam logic [3:0] DIG_POL = 4'hF;
`else
    localparam logic [6:0] SEG_POL = 7'h00;
    localparam logic [3:0] DIG_POL = 4'h0;
`endif

    logic [1:0]      d_q, d_d;
    logic [CW-1:0]   c_q, c_d;
    logic [3:0][6:0] shadow_q, shadow_d;
    logic [2:0]      bright_q, bright_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      dig_q, dig_d;
    logic            frame_q, frame_d;

    logic            capture_s;
    logic            active_s;
    logic [CW:0]     on_end_s;

    // Scan sequencing, frame capture and registered output decode
    always_comb begin
        d_d       = d_q;
        c_d       = c_q;
        shadow_d  = shadow_q;
        bright_d  = bright_q;
        seg_d     = SEG_POL;
        dig_d     = DIG_POL;
        capture_s = bus.en_i && (d_q == 2'd0) && (c_q == C_ZERO);
        frame_d   = capture_s;

        if (!bus.en_i) begin
            d_d = 2'd0;
            c_d = C_ZERO;
        end else if (c_q == C_LAST) begin
            d_d = d_q + 2'd1;
            c_d = C_ZERO;
        end else begin
            c_d = c_q + C_ONE;
        end

        // The capture edge always renders c = 0, which is dark, so fresh shadows
        // are in place before the first lit cycle of the frame.
        if (capture_s) begin
            shadow_d = {bus.seg_xxxm_i, bus.seg_xxmx_i, bus.seg_xhxx_i, bus.seg_hxxx_i};
            bright_d = bus.bright_i;
        end else begin
            shadow_d = shadow_q;
            bright_d = bright_q;
        end

        on_end_s = (((CW+1)'(bright_q)) + W_ONE) * STEP - W_ONE;
        active_s = bus.en_i && (c_q != C_ZERO) && ({1'b0, c_q} <= on_end_s);

        if (active_s) begin
            dig_d = (4'b0001 << d_q) ^ DIG_POL;
            seg_d = shadow_q[d_q] ^ SEG_POL;
        end else begin
            dig_d = DIG_POL;
            seg_d = SEG_POL;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q      <= 2'd0;
            c_q      <= C_ZERO;
            shadow_q <= {4{7'h00}};
            bright_q <= 3'd0;
            seg_q    <= SEG_POL;
            dig_q    <= DIG_POL;
            frame_q  <= 1'b0;
        end else begin
            d_q      <= d_d;
            c_q      <= c_d;
            shadow_q <= shadow_d;
            bright_q <= bright_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
            frame_q  <= frame_d;
        end
    end

    assign bus.seg_o   = seg_q;
    assign bus.dig_o   = dig_q;
    assign bus.frame_o = frame_q;
endmodule

// File: tb/tb_segment_scan_mux.sv
// Directed bench for segment_scan_mux at SCAN_DIV = 32 (frame = 128 clocks).
// Honours SEG_ACTIVE_LOW_EN by un-inverting the observed bus before checking.
module tb_segment_scan_mux;
`ifdef SEG_ACTIVE_LOW_EN
    localparam logic [6:0] SEG_POL = 7'h7F;
    localparam logic [3:0] DIG_POL = 4'hF;
`else
    localparam logic [6:0] SEG_POL = 7'h00;
    localparam logic [3:0] DIG_POL = 4'h0;
`endif

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   fail_cnt;
    int   total_cnt;

    int   lit_n   [4];
    int   first_o [4];
    int   last_o  [4];
    int   code_v  [4];
    int   frames_n;
    int   frame_at;
    int   bad_n;
    int   off;

    segment_scan_mux_if bus_if ();

    segment_scan_mux #(.SCAN_DIV(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " seg"}, int'(bus_if.seg_o), int'(SEG_POL));
        chk({tag, " dig"}, int'(bus_if.dig_o), int'(DIG_POL));
        chk({tag, " frame"}, int'(bus_if.frame_o), 0);
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) begin
            lit_n[i]   = 0;
            first_o[i] = -1;
            last_o[i]  = -1;
            code_v[i]  = -1;
        end
        frames_n = 0;
        frame_at = -1;
        bad_n    = 0;
        off      = 0;
    endtask

    task automatic obs_cycles(input int n);
        logic [6:0] s;
        logic [3:0] g;
        for (int k = 0; k < n; k++) begin
            tick();
            s = bus_if.seg_o ^ SEG_POL;
            g = bus_if.dig_o ^ DIG_POL;
            if (bus_if.frame_o) begin
                frames_n++;
                frame_at = off;
            end
            if (g == 4'd0) begin
                if (s != 7'd0) bad_n++;
            end else if ($countones(g) != 1) begin
                bad_n++;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (g[i]) begin
                        lit_n[i]++;
                        if (first_o[i] < 0) begin
                            first_o[i] = off;
                            code_v[i]  = int'(s);
                        end else if (code_v[i] != int'(s)) begin
                            bad_n++;
                        end
                        last_o[i] = off;
                    end
                end
            end
            off++;
        end
    endtask

    // Window offset 0 is the capture edge; slot i is lit at offsets 32*i+1 .. 32*i+lit_e.
    task automatic chk_window(input string tag, input int lit_e,
                              input int c0, input int c1, input int c2, input int c3);
        int codes [4];
        codes = '{c0, c1, c2, c3};
        chk({tag, " frames"},   frames_n, 1);
        chk({tag, " frame_at"}, frame_at, 0);
        chk({tag, " bad"},      bad_n,    0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s lit%0d", tag, i),   lit_n[i],   lit_e);
            chk($sformatf("%s first%0d", tag, i), first_o[i], 32 * i + 1);
            chk($sformatf("%s last%0d", tag, i),  last_o[i],  32 * i + lit_e);
            chk($sformatf("%s code%0d", tag, i),  code_v[i],  codes[i]);
        end
    endtask

    initial begin
        pass_cnt  = 0;
        fail_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b1;
        bus_if.en_i       = 1'b1;
        bus_if.bright_i   = 3'd7;
        bus_if.seg_hxxx_i = 7'h06;
        bus_if.seg_xhxx_i = 7'h5B;
        bus_if.seg_xxmx_i = 7'h4F;
        bus_if.seg_xxxm_i = 7'h66;
        #1 rst_n = 1'b0;
        repeat (2) tick();
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full brightness after reset
        clear_stats();
        obs_cycles(128);
        chk_window("b7", 31, 'h06, 'h5B, 'h4F, 'h66);

        // Dimmest, with a mid-frame brightness change that must wait a frame
        bus_if.bright_i = 3'd0;
        clear_stats();
        obs_cycles(50);
        bus_if.bright_i = 3'd3;
        obs_cycles(78);
        chk_window("b0", 3, 'h06, 'h5B, 'h4F, 'h66);

        // Bright 3, minute-tens code changes while slot 1 is on
        clear_stats();
        obs_cycles(40);
        bus_if.seg_xxmx_i = 7'h7D;
        obs_cycles(88);
        chk_window("b3", 15, 'h06, 'h5B, 'h4F, 'h66);
        bus_if.bright_i = 3'd7;

        clear_stats();
        obs_cycles(128);
        chk_window("newcode", 31, 'h06, 'h5B, 'h7D, 'h66);

        // Disable at slot 2, c = 10
        clear_stats();
        obs_cycles(74);
        chk("pre_dis dig", int'(bus_if.dig_o), int'(4'b0100 ^ DIG_POL));
        bus_if.en_i = 1'b0;
        tick();
        chk_idle("dis1");
        repeat (5) tick();
        chk_idle("dis6");
        bus_if.en_i = 1'b1;
        clear_stats();
        obs_cycles(128);
        chk_window("reen", 31, 'h06, 'h5B, 'h7D, 'h66);

        // Asynchronous reset at slot 3, c = 20
        clear_stats();
        obs_cycles(116);
        chk("pre_rst dig", int'(bus_if.dig_o), int'(4'b1000 ^ DIG_POL));
        #2 rst_n = 1'b0;
        #1 chk_idle("async_rst");
        #2 rst_n = 1'b1;
        clear_stats();
        obs_cycles(128);
        chk_window("post_rst", 31, 'h06, 'h5B, 'h7D, 'h66);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
